mem_1r1w_rd_arbiter: RTL and testbench

//  Shares the read port of a 1R1W synchronous memory macro (1-cycle read latency) among N_RD clients.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_rr.sv | 46 ++++
 rtl/mem_1r1w_rd_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_1r1w_rd_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the 1R1W read-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INFLIGHT,
    STALL
  } state_e;

  // Owner/pointer width is sized for the largest supported client count (8)
  // so every instance shares one owner type.
  localparam int N_RD_MAX = 8;
  localparam int OWNER_W  = (N_RD_MAX > 1) ? $clog2(N_RD_MAX) : 1;

  typedef logic [OWNER_W-1:0] owner_t;

  function automatic owner_t rr_next(input owner_t idx, input int n);
    if (int'(idx) + 1 >= n) return '0;
    return idx + owner_t'(1);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational round-robin picker: first valid client at or after ptr_i.
module mem_arb_rr
  import mem_arb_pkg::*;
#(
  parameter int N_RD = 2
) (
  input  logic [N_RD-1:0] valid_i,
  input  owner_t          ptr_i,
  input  logic            en_i,
  output logic [N_RD-1:0] gnt_o,
  output owner_t          idx_o,
  output logic            any_o
);

  logic [N_RD-1:0] rot;
  logic            found;
  owner_t          idx;
  int              sum;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    rot   = N_RD'({valid_i, valid_i} >> ptr_i);
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    if (en_i) begin
      for (int k = 0; k < N_RD; k++) begin
        if (!found && rot[k]) begin
          found = 1'b1;
          sum   = int'(ptr_i) + k;
          if (sum >= N_RD) sum = sum - N_RD;
          idx   = owner_t'(sum);
        end
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int j = 0; j < N_RD; j++) gnt_o[j] = found && (int'(idx) == j);
  end

  assign idx_o = idx;
  assign any_o = found;

endmodule

// File: rtl/mem_1r1w_rd_arbiter.sv
// Round-robin sharing of a 1R1W memory read port among N_RD clients, with a skid for refused responses.
// Optional write-first collision bypass: define MEM_ARB_WR_BYPASS_EN.
module mem_1r1w_rd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_RD   = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_RD-1:0]        rd_req_valid,
  output logic [N_RD-1:0]        rd_req_ready,
  input  logic [N_RD*ADDR_W-1:0] rd_req_addr,
  output logic [N_RD-1:0]        rd_rsp_valid,
  input  logic [N_RD-1:0]        rd_rsp_ready,
  output logic [DATA_W-1:0]      rd_rsp_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic [ADDR_W-1:0]      R0_addr,
  output logic                   R0_en,
  input  logic [DATA_W-1:0]      R0_data,
  output logic [ADDR_W-1:0]      W0_addr,
  output logic                   W0_en,
  output logic [DATA_W-1:0]      W0_data
);

  state_e              state_q, state_d;
  owner_t              rr_ptr_q, rr_ptr_d;
  owner_t              owner_q, owner_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [ADDR_W-1:0]   r0_addr_q;

  logic [N_RD-1:0]     owner_oh;
  logic                owner_rdy;
  logic                issue_ok;
  logic [N_RD-1:0]     gnt;
  owner_t              gnt_idx;
  logic                gnt_any;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   inflight_data;

  // Writes bypass the arbiter entirely and are only masked while in reset.
  assign wr_ready = reset_n;
  assign W0_en    = wr_valid & reset_n;
  assign W0_addr  = wr_addr;
  assign W0_data  = wr_data;

  always_comb begin
    owner_oh  = '0;
    owner_rdy = 1'b0;
    for (int j = 0; j < N_RD; j++) begin
      owner_oh[j] = (int'(owner_q) == j);
      if (owner_oh[j]) owner_rdy = rd_rsp_ready[j];
    end
  end

  assign issue_ok = (state_q == IDLE) || ((state_q == INFLIGHT) && owner_rdy);

  mem_arb_rr #(.N_RD(N_RD)) u_rr (
    .valid_i (rd_req_valid),
    .ptr_i   (rr_ptr_q),
    .en_i    (issue_ok & reset_n),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  always_comb begin
    sel_addr = '0;
    for (int j = 0; j < N_RD; j++) begin
      if (gnt[j]) sel_addr = rd_req_addr[j*ADDR_W +: ADDR_W];
    end
  end

`ifdef MEM_ARB_WR_BYPASS_EN
  logic              byp_hit_q;
  logic [DATA_W-1:0] byp_data_q;

  // A write landing on the granted read address wins: its data replaces the macro output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else if (gnt_any) begin
      byp_hit_q  <= W0_en && (W0_addr == R0_addr);
      byp_data_q <= W0_data;
    end
  end

  assign inflight_data = byp_hit_q ? byp_data_q : R0_data;
`else
  assign inflight_data = R0_data;
`endif

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    skid_d       = skid_q;
    rd_req_ready = gnt;
    R0_en        = gnt_any;
    R0_addr      = gnt_any ? sel_addr : r0_addr_q;
    rd_rsp_valid = '0;
    rd_rsp_data  = skid_q;

    if (gnt_any) begin
      owner_d  = gnt_idx;
      rr_ptr_d = rr_next(gnt_idx, N_RD);
    end

    unique case (state_q)
      IDLE: begin
        if (gnt_any) state_d = INFLIGHT;
      end
      INFLIGHT: begin
        rd_rsp_valid = owner_oh;
        rd_rsp_data  = inflight_data;
        if (owner_rdy) begin
          state_d = gnt_any ? INFLIGHT : IDLE;
        end else begin
          // The macro output is only valid for one cycle; park it so the response stays stable.
          state_d = STALL;
          skid_d  = inflight_data;
        end
      end
      STALL: begin
        rd_rsp_valid = owner_oh;
        if (owner_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      skid_q    <= '0;
      r0_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      skid_q    <= skid_d;
      r0_addr_q <= R0_addr;
    end
  end

endmodule

// File: tb/tb_mem_1r1w_rd_arbiter.sv
// Directed self-checking bench for mem_1r1w_rd_arbiter with a behavioural 1R1W macro model.
module tb_mem_1r1w_rd_arbiter;

  localparam int N_RD   = 2;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;

  logic                   clock;
  logic                   reset_n;
  logic [N_RD-1:0]        rd_req_valid;
  logic [N_RD-1:0]        rd_req_ready;
  logic [N_RD*ADDR_W-1:0] rd_req_addr;
  logic [N_RD-1:0]        rd_rsp_valid;
  logic [N_RD-1:0]        rd_rsp_ready;
  logic [DATA_W-1:0]      rd_rsp_data;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic [ADDR_W-1:0]      R0_addr;
  logic                   R0_en;
  logic [DATA_W-1:0]      R0_data;
  logic [ADDR_W-1:0]      W0_addr;
  logic                   W0_en;
  logic [DATA_W-1:0]      W0_data;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  mem_1r1w_rd_arbiter #(.N_RD(N_RD), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_data  (rd_rsp_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .R0_addr      (R0_addr),
    .R0_en        (R0_en),
    .R0_data      (R0_data),
    .W0_addr      (W0_addr),
    .W0_en        (W0_en),
    .W0_data      (W0_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Macro model: read-before-write, one cycle read latency.
  always @(posedge clock) begin
    if (W0_en) mem[W0_addr] <= W0_data;
    if (R0_en) R0_data <= mem[R0_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fill();
    for (int a = 0; a < 2**ADDR_W; a++) begin
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'(a);
      wr_data  = DATA_W'(a * 3);
      step();
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    logic [N_RD-1:0] exp_gnt;
    logic [N_RD-1:0] prev_gnt;

    reset_n      = 1'b0;
    rd_req_valid = '0;
    rd_req_addr  = '0;
    rd_rsp_ready = '0;
    wr_valid     = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    step();
    reset_n = 1'b1;
    step();
    fill();

    // Reset with every request line high.
    reset_n      = 1'b0;
    rd_req_valid = 2'b11;
    wr_valid     = 1'b1;
    rd_req_addr  = {5'd2, 5'd1};
    rd_rsp_ready = 2'b11;
    repeat (3) step();
    check("rst_rd_req_ready", rd_req_ready, 0);
    check("rst_rd_rsp_valid", rd_rsp_valid, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_R0_en", R0_en, 0);
    check("rst_W0_en", W0_en, 0);
    wr_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    check("first_grant_client0", rd_req_ready, 2'b01);

    // Fairness: both request continuously, grants alternate, one response per cycle.
    prev_gnt = '0;
    for (int k = 0; k < 6; k++) begin
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("fair_gnt_%0d", k), rd_req_ready, exp_gnt);
      check($sformatf("fair_r0en_%0d", k), R0_en, 1);
      if (k > 0) begin
        check($sformatf("fair_rspv_%0d", k), rd_rsp_valid, prev_gnt);
        check($sformatf("fair_data_%0d", k), rd_rsp_data, (prev_gnt == 2'b01) ? 64'd3 : 64'd6);
      end
      prev_gnt = exp_gnt;
      step();
    end
    rd_req_valid = '0;
    #1;
    check("fair_tail_rspv", rd_rsp_valid, 2'b10);
    check("fair_tail_data", rd_rsp_data, 64'd6);
    check("fair_tail_gnt", rd_req_ready, 0);
    step();
    check("fair_idle_rspv", rd_rsp_valid, 0);

    // Backpressure: client 1 reads a freshly written word while refusing the response.
    wr_valid = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 64'hDEAD_BEEF_0000_0001;
    #1;
    check("wr_W0_en", W0_en, 1);
    check("wr_wr_ready", wr_ready, 1);
    check("wr_W0_addr", W0_addr, 3);
    check("wr_W0_data", W0_data, 64'hDEAD_BEEF_0000_0001);
    step();
    wr_valid     = 1'b0;
    rd_req_valid = 2'b10;
    rd_req_addr  = {5'd3, 5'd0};
    rd_rsp_ready = 2'b00;
    #1;
    check("bp_gnt", rd_req_ready, 2'b10);
    check("bp_R0_addr", R0_addr, 3);
    step();
    for (int c = 0; c < 4; c++) begin
      check($sformatf("bp_rspv_%0d", c), rd_rsp_valid, 2'b10);
      check($sformatf("bp_data_%0d", c), rd_rsp_data, 64'hDEAD_BEEF_0000_0001);
      check($sformatf("bp_no_r0en_%0d", c), R0_en, 0);
      check($sformatf("bp_no_gnt_%0d", c), rd_req_ready, 0);
      step();
    end
    rd_rsp_ready = 2'b10;
    #1;
    check("bp_drain_rspv", rd_rsp_valid, 2'b10);
    check("bp_drain_data", rd_rsp_data, 64'hDEAD_BEEF_0000_0001);
    check("bp_drain_no_r0en", R0_en, 0);
    step();
    check("bp_resume_gnt", rd_req_ready, 2'b10);
    check("bp_resume_r0en", R0_en, 1);
    step();
    rd_req_valid = '0;
    #1;
    check("bp_resume_rspv", rd_rsp_valid, 2'b10);
    step();

    // Reset while a refused response sits in the skid.
    rd_req_valid = 2'b01;
    rd_req_addr  = {5'd0, 5'd3};
    rd_rsp_ready = 2'b00;
    #1;
    check("mid_gnt", rd_req_ready, 2'b01);
    step();
    rd_req_valid = '0;
    step();
    check("mid_stall_rspv", rd_rsp_valid, 2'b01);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rspv", rd_rsp_valid, 0);
    check("mid_rst_gnt", rd_req_ready, 0);
    step();
    reset_n      = 1'b1;
    rd_rsp_ready = 2'b11;
    #1;
    check("mid_rel_rspv", rd_rsp_valid, 0);
    step();
    check("mid_rel_rspv2", rd_rsp_valid, 0);

    // Back-to-back reads of the whole memory by client 0.
    fill();
    rd_rsp_ready = 2'b01;
    for (int i = 0; i <= 32; i++) begin
      rd_req_valid = (i < 32) ? 2'b01 : 2'b00;
      rd_req_addr  = {5'd0, 5'(i)};
      #1;
      if (i < 32) check($sformatf("b2b_gnt_%0d", i), rd_req_ready, 2'b01);
      if (i > 0) begin
        check($sformatf("b2b_rspv_%0d", i), rd_rsp_valid, 2'b01);
        check($sformatf("b2b_data_%0d", i), rd_rsp_data, 64'((i - 1) * 3));
      end
      step();
    end
    check("b2b_idle_rspv", rd_rsp_valid, 0);

    // Same-cycle write and read of one address.
    wr_valid = 1'b1;
    wr_addr  = 5'd7;
    wr_data  = 64'h11;
    step();
    wr_data      = 64'h22;
    rd_req_valid = 2'b01;
    rd_req_addr  = {5'd0, 5'd7};
    #1;
    check("col_gnt", rd_req_ready, 2'b01);
    step();
    wr_valid     = 1'b0;
    rd_req_valid = '0;
    #1;
    check("col_rspv", rd_rsp_valid, 2'b01);
`ifdef MEM_ARB_WR_BYPASS_EN
    check("col_data", rd_rsp_data, 64'h22);
`endif
    step();

    // Concurrent write to a different address does not disturb the read.
    wr_valid     = 1'b1;
    wr_addr      = 5'd9;
    wr_data      = 64'h33;
    rd_req_valid = 2'b01;
    rd_req_addr  = {5'd0, 5'd7};
    #1;
    check("nocol_gnt", rd_req_ready, 2'b01);
    step();
    wr_valid     = 1'b0;
    rd_req_valid = '0;
    #1;
    check("nocol_data", rd_rsp_data, 64'h22);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
